// File: rtl/mem_bus_arbiter_if.sv
// Bundle of both requester ports plus the shared slave port of the memory bus arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory side.
interface mem_bus_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    localparam int MW = DW / 8;

    logic          if_request;
    logic          if_a_valid;
    logic          if_a_ready;
    logic [2:0]    if_a_opcode;
    logic [AW-1:0] if_a_address;
    logic [DW-1:0] if_a_data;
    logic [MW-1:0] if_a_mask;
    logic          if_d_valid;
    logic          if_d_ready;
    logic [DW-1:0] if_d_data;
    logic          if_d_denied;

    logic          ma_request;
    logic          ma_a_valid;
    logic          ma_a_ready;
    logic [2:0]    ma_a_opcode;
    logic [AW-1:0] ma_a_address;
    logic [DW-1:0] ma_a_data;
    logic [MW-1:0] ma_a_mask;
    logic          ma_d_valid;
    logic          ma_d_ready;
    logic [DW-1:0] ma_d_data;
    logic          ma_d_denied;

    logic          s_a_valid;
    logic          s_a_ready;
    logic [2:0]    s_a_opcode;
    logic [AW-1:0] s_a_address;
    logic [DW-1:0] s_a_data;
    logic [MW-1:0] s_a_mask;
    logic          s_d_valid;
    logic          s_d_ready;
    logic [DW-1:0] s_d_data;
    logic          s_d_denied;

    logic          grant_if;
    logic          grant_ma;
    logic          busy;

    modport slave (
        input  if_request, if_a_valid, if_a_opcode, if_a_address, if_a_data, if_a_mask, if_d_ready,
        output if_a_ready, if_d_valid, if_d_data, if_d_denied,
        input  ma_request, ma_a_valid, ma_a_opcode, ma_a_address, ma_a_data, ma_a_mask, ma_d_ready,
        output ma_a_ready, ma_d_valid, ma_d_data, ma_d_denied,
        output s_a_valid, s_a_opcode, s_a_address, s_a_data, s_a_mask, s_d_ready,
        input  s_a_ready, s_d_valid, s_d_data, s_d_denied,
        output grant_if, grant_ma, busy
    );

    modport master (
        output if_request, if_a_valid, if_a_opcode, if_a_address, if_a_data, if_a_mask, if_d_ready,
        input  if_a_ready, if_d_valid, if_d_data, if_d_denied,
        output ma_request, ma_a_valid, ma_a_opcode, ma_a_address, ma_a_data, ma_a_mask, ma_d_ready,
        input  ma_a_ready, ma_d_valid, ma_d_data, ma_d_denied,
        input  s_a_valid, s_a_opcode, s_a_address, s_a_data, s_a_mask, s_d_ready,
        output s_a_ready, s_d_valid, s_d_data, s_d_denied,
        input  grant_if, grant_ma, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch/memory-access) to one-slave arbiter, one transaction in flight, ma-priority with fetch anti-starvation.
// Grant 1 cycle after eligibility, then A and D pass through combinationally; slave ready/valid stall the owner only.
module mem_bus_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    mem_bus_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant_if_q, grant_if_d;
    logic          grant_ma_q, grant_ma_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    logic if_elig, ma_elig;
    logic pick_if, pick_ma;
    logic in_addr, in_resp;
    logic own_request, own_a_valid, own_d_ready;
    logic kill_fetch, s_a_valid_int, a_fire, s_d_ready_int, d_fire;

    always_comb begin
        if_elig     = bus.if_request & bus.if_a_valid;
        ma_elig     = bus.ma_request & bus.ma_a_valid;
        in_addr     = (state_q == ADDR);
        in_resp     = (state_q == RESP);
        own_request = (grant_if_q & bus.if_request) | (grant_ma_q & bus.ma_request);
        own_a_valid = (grant_if_q & bus.if_a_valid) | (grant_ma_q & bus.ma_a_valid);
        own_d_ready = (grant_if_q & bus.if_d_ready) | (grant_ma_q & bus.ma_d_ready);
        // A flush abandons an un-accepted fetch; the slave must never see it that cycle.
        kill_fetch    = in_addr & grant_if_q & clear;
        s_a_valid_int = in_addr & own_a_valid & ~kill_fetch;
        a_fire        = s_a_valid_int & bus.s_a_ready;
        s_d_ready_int = in_resp & own_d_ready;
        d_fire        = s_d_ready_int & bus.s_d_valid;
    end

    always_comb begin
        bus.s_a_valid   = s_a_valid_int;
        bus.s_d_ready   = s_d_ready_int;
        bus.if_a_ready  = in_addr & grant_if_q & bus.s_a_ready & ~kill_fetch;
        bus.ma_a_ready  = in_addr & grant_ma_q & bus.s_a_ready;
        bus.if_d_valid  = in_resp & grant_if_q & bus.s_d_valid;
        bus.ma_d_valid  = in_resp & grant_ma_q & bus.s_d_valid;
        bus.if_d_data   = (in_resp & grant_if_q) ? bus.s_d_data : '0;
        bus.ma_d_data   = (in_resp & grant_ma_q) ? bus.s_d_data : '0;
        bus.if_d_denied = in_resp & grant_if_q & bus.s_d_denied;
        bus.ma_d_denied = in_resp & grant_ma_q & bus.s_d_denied;
        bus.grant_if    = grant_if_q;
        bus.grant_ma    = grant_ma_q;
        bus.busy        = (state_q != IDLE);
    end

    always_comb begin
        bus.s_a_opcode  = '0;
        bus.s_a_address = '0;
        bus.s_a_data    = '0;
        bus.s_a_mask    = '0;
        if (grant_if_q) begin
            bus.s_a_opcode  = bus.if_a_opcode;
            bus.s_a_address = bus.if_a_address;
            bus.s_a_data    = bus.if_a_data;
            bus.s_a_mask    = bus.if_a_mask;
        end else if (grant_ma_q) begin
            bus.s_a_opcode  = bus.ma_a_opcode;
            bus.s_a_address = bus.ma_a_address;
            bus.s_a_data    = bus.ma_a_data;
            bus.s_a_mask    = bus.ma_a_mask;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_if_d   = grant_if_q;
        grant_ma_d   = grant_ma_q;
        starve_cnt_d = starve_cnt_q;
        pick_if      = 1'b0;
        pick_ma      = 1'b0;
        unique case (state_q)
            IDLE: begin
                pick_if    = if_elig & ~clear & (~ma_elig | (starve_cnt_q == STARVE_LIM));
                pick_ma    = ma_elig & ~pick_if;
                grant_if_d = pick_if;
                grant_ma_d = pick_ma;
                if (pick_if | pick_ma) begin
                    state_d = ADDR;
                end
                if (pick_if) begin
                    starve_cnt_d = '0;
                end else if (pick_ma & if_elig & (starve_cnt_q != STARVE_LIM)) begin
                    starve_cnt_d = starve_cnt_q + CW'(1);
                end
            end
            ADDR: begin
                if (a_fire) begin
                    state_d = RESP;
                end else if (~own_request | kill_fetch) begin
                    state_d    = IDLE;
                    grant_if_d = 1'b0;
                    grant_ma_d = 1'b0;
                end
            end
            RESP: begin
                if (d_fire) begin
                    state_d    = IDLE;
                    grant_if_d = 1'b0;
                    grant_ma_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_if_d = 1'b0;
                grant_ma_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_if_q   <= 1'b0;
            grant_ma_q   <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_if_q   <= grant_if_d;
            grant_ma_q   <= grant_ma_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: transaction-level reference model checked every negedge plus literal spot checks.
module tb_mem_bus_arbiter;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int SMAX = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic clear = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk  (clk),
        .rst  (rst),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the bus (0 none, 1 fetch, 2 memory access), whether its
    // request has been accepted by the slave, and how many ma wins fetch has sat through.
    int          m_own  = 0;
    bit          m_acc  = 1'b0;
    int          m_wait = 0;
    logic        o_req, o_av, o_dr, ph_a, kill;
    logic        e_sav, e_ardy, e_dv;
    logic [63:0] o_addr, o_data;
    bit          if_ok, ma_ok;
    int          grant_log[$];
    logic        prev_g = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            m_own  = 0;
            m_acc  = 1'b0;
            m_wait = 0;
        end
        o_req  = (m_own == 1) ? bus.if_request   : (m_own == 2) ? bus.ma_request   : 1'b0;
        o_av   = (m_own == 1) ? bus.if_a_valid   : (m_own == 2) ? bus.ma_a_valid   : 1'b0;
        o_dr   = (m_own == 1) ? bus.if_d_ready   : (m_own == 2) ? bus.ma_d_ready   : 1'b0;
        o_addr = (m_own == 1) ? bus.if_a_address : (m_own == 2) ? bus.ma_a_address : 64'd0;
        o_data = (m_own == 1) ? bus.if_a_data    : (m_own == 2) ? bus.ma_a_data    : 64'd0;
        ph_a   = (m_own != 0) && !m_acc;
        kill   = ph_a && (m_own == 1) && clear;
        e_sav  = ph_a && o_av && !kill;
        e_ardy = ph_a && bus.s_a_ready && !kill;
        e_dv   = m_acc && bus.s_d_valid;

        check("grant_if",    bus.grant_if,    m_own == 1);
        check("grant_ma",    bus.grant_ma,    m_own == 2);
        check("busy",        bus.busy,        m_own != 0);
        check("s_a_valid",   bus.s_a_valid,   e_sav);
        check("s_a_address", bus.s_a_address, o_addr);
        check("s_a_data",    bus.s_a_data,    o_data);
        check("if_a_ready",  bus.if_a_ready,  (m_own == 1) && e_ardy);
        check("ma_a_ready",  bus.ma_a_ready,  (m_own == 2) && e_ardy);
        check("s_d_ready",   bus.s_d_ready,   m_acc && o_dr);
        check("if_d_valid",  bus.if_d_valid,  (m_own == 1) && e_dv);
        check("ma_d_valid",  bus.ma_d_valid,  (m_own == 2) && e_dv);
        check("if_d_data",   bus.if_d_data,   ((m_own == 1) && m_acc) ? bus.s_d_data : 64'd0);
        check("ma_d_data",   bus.ma_d_data,   ((m_own == 2) && m_acc) ? bus.s_d_data : 64'd0);
        check("ma_d_denied", bus.ma_d_denied, (m_own == 2) && m_acc && bus.s_d_denied);

        if (!rst && (bus.grant_if || bus.grant_ma) && !prev_g) grant_log.push_back(bus.grant_if ? 1 : 2);
        prev_g = !rst && (bus.grant_if || bus.grant_ma);

        if (!rst) begin
            if (m_own == 0) begin
                if_ok = bus.if_request && bus.if_a_valid;
                ma_ok = bus.ma_request && bus.ma_a_valid;
                if (if_ok && !clear && (!ma_ok || m_wait >= SMAX)) begin
                    m_own  = 1;
                    m_wait = 0;
                end else if (ma_ok) begin
                    m_own = 2;
                    if (if_ok && m_wait < SMAX) m_wait++;
                end
            end else if (!m_acc) begin
                if (e_sav && bus.s_a_ready) m_acc = 1'b1;
                else if (!o_req || kill) m_own = 0;
            end else if (bus.s_d_valid && o_dr) begin
                m_own = 0;
                m_acc = 1'b0;
            end
        end
    end

    initial begin
        int exp_grants[6];
        exp_grants = '{2, 2, 2, 2, 1, 2};

        bus.if_request = 0; bus.if_a_valid = 0; bus.if_a_opcode = 0; bus.if_a_address = 0;
        bus.if_a_data = 0; bus.if_a_mask = 0; bus.if_d_ready = 0;
        bus.ma_request = 0; bus.ma_a_valid = 0; bus.ma_a_opcode = 0; bus.ma_a_address = 0;
        bus.ma_a_data = 0; bus.ma_a_mask = 0; bus.ma_d_ready = 0;
        bus.s_a_ready = 0; bus.s_d_valid = 0; bus.s_d_data = 0; bus.s_d_denied = 0;

        #1 rst = 1'b1;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_grant", {bus.grant_if, bus.grant_ma}, 2'b00);
        check("rst_s_a_valid", bus.s_a_valid, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // 1: fetch alone, minimum turnaround
        bus.if_request = 1; bus.if_a_valid = 1; bus.if_a_opcode = 3'd4;
        bus.if_a_address = 64'h8000_0000; bus.if_a_mask = 8'hff;
        bus.s_a_ready = 1; bus.if_d_ready = 1;
        tick(1);
        check("t1_grant_if", bus.grant_if, 1'b1);
        check("t1_if_a_ready", bus.if_a_ready, 1'b1);
        check("t1_s_a_address", bus.s_a_address, 64'h8000_0000);
        bus.s_d_valid = 1; bus.s_d_data = 64'h13;
        tick(1);
        check("t1_if_d_valid", bus.if_d_valid, 1'b1);
        check("t1_if_d_data", bus.if_d_data, 64'h13);
        bus.if_request = 0; bus.if_a_valid = 0;
        tick(1);
        check("t1_busy_low", bus.busy, 1'b0);
        bus.s_d_valid = 0; bus.s_d_data = 0;

        // 2: both request continuously; fetch forced through after 4 ma wins
        grant_log.delete();
        bus.if_request = 1; bus.if_a_valid = 1;
        bus.ma_request = 1; bus.ma_a_valid = 1; bus.ma_a_address = 64'h4000; bus.ma_a_data = 64'h1234;
        bus.s_a_ready = 1; bus.s_d_valid = 1; bus.s_d_data = 64'h5a; bus.if_d_ready = 1; bus.ma_d_ready = 1;
        tick(18);
        bus.if_request = 0; bus.if_a_valid = 0; bus.ma_request = 0; bus.ma_a_valid = 0;
        check("t2_grant_count", grant_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check($sformatf("t2_grant_%0d", i), grant_log[i], exp_grants[i]);
        end
        tick(1);
        bus.s_a_ready = 0; bus.s_d_valid = 0; bus.s_d_data = 0;
        tick(2);

        // 3: slave A backpressure on an ma store
        bus.ma_request = 1; bus.ma_a_valid = 1; bus.ma_a_address = 64'h1000; bus.ma_a_data = 64'h55;
        bus.s_a_ready = 0; bus.s_d_valid = 1; bus.s_d_data = 64'hdead; bus.ma_d_ready = 1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("t3_addr_stable", bus.s_a_address, 64'h1000);
            check("t3_ma_a_ready", bus.ma_a_ready, 1'b0);
            check("t3_ma_d_valid", bus.ma_d_valid, 1'b0);
        end
        tick(1);
        bus.s_a_ready = 1;
        #1;
        check("t3_fire_cycle6", bus.ma_a_ready, 1'b1);
        tick(1);
        check("t3_ma_d_data", bus.ma_d_data, 64'hdead);
        bus.ma_request = 0; bus.ma_a_valid = 0; bus.s_a_ready = 0;
        tick(1);
        check("t3_busy_low", bus.busy, 1'b0);
        bus.s_d_valid = 0; bus.s_d_data = 0;

        // 4a: flush abandons a stalled fetch
        bus.if_request = 1; bus.if_a_valid = 1; bus.if_a_address = 64'h8000_0040; bus.s_a_ready = 0;
        tick(1);
        check("t4_grant_if", bus.grant_if, 1'b1);
        clear = 1;
        #1;
        check("t4_kill_s_a_valid", bus.s_a_valid, 1'b0);
        check("t4_kill_if_a_ready", bus.if_a_ready, 1'b0);
        tick(1);
        check("t4_back_idle", bus.busy, 1'b0);
        clear = 0; bus.if_request = 0; bus.if_a_valid = 0;
        tick(1);
        // 4b: the same flush does not touch an ma transaction
        bus.ma_request = 1; bus.ma_a_valid = 1; bus.ma_a_address = 64'h2000; bus.ma_d_ready = 1;
        tick(1);
        clear = 1;
        #1;
        check("t4_ma_s_a_valid", bus.s_a_valid, 1'b1);
        tick(1);
        check("t4_ma_keeps_grant", bus.grant_ma, 1'b1);
        clear = 0; bus.s_a_ready = 1; bus.s_d_valid = 1; bus.s_d_data = 64'h77;
        tick(1);
        check("t4_ma_d_data", bus.ma_d_data, 64'h77);
        bus.ma_request = 0; bus.ma_a_valid = 0;
        tick(1);
        check("t4_ma_done", bus.busy, 1'b0);
        bus.s_d_valid = 0; bus.s_d_data = 0; bus.s_a_ready = 0;

        // 5: early D in IDLE held off; D stall and error propagation
        bus.s_d_valid = 1; bus.s_d_data = 64'habcd; bus.s_d_denied = 1;
        #1;
        check("t5_idle_s_d_ready", bus.s_d_ready, 1'b0);
        check("t5_idle_d_valid", {bus.if_d_valid, bus.ma_d_valid}, 2'b00);
        tick(1);
        bus.ma_request = 1; bus.ma_a_valid = 1; bus.ma_a_address = 64'h3000;
        bus.ma_d_ready = 0; bus.s_a_ready = 1;
        tick(2);
        bus.ma_request = 0; bus.ma_a_valid = 0; bus.s_a_ready = 0;
        for (int k = 0; k < 3; k++) begin
            check("t5_s_d_ready_held", bus.s_d_ready, 1'b0);
            check("t5_ma_d_data_held", bus.ma_d_data, 64'habcd);
            check("t5_ma_d_denied", bus.ma_d_denied, 1'b1);
            tick(1);
        end
        bus.ma_d_ready = 1;
        #1;
        check("t5_s_d_ready_rise", bus.s_d_ready, 1'b1);
        tick(1);
        check("t5_done", bus.busy, 1'b0);
        bus.s_d_valid = 0; bus.s_d_data = 0; bus.s_d_denied = 0; bus.ma_d_ready = 0;

        // 6: asynchronous reset in RESP
        bus.ma_request = 1; bus.ma_a_valid = 1; bus.ma_a_address = 64'h6000; bus.s_a_ready = 1;
        bus.s_d_valid = 1; bus.s_d_data = 64'h99;
        tick(2);
        bus.ma_request = 0; bus.ma_a_valid = 0;
        check("t6_in_resp", bus.ma_d_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_grant_ma", bus.grant_ma, 1'b0);
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_ma_d_valid", bus.ma_d_valid, 1'b0);
        check("t6_rst_ma_d_data", bus.ma_d_data, 64'd0);
        check("t6_rst_s_d_ready", bus.s_d_ready, 1'b0);
        bus.s_d_valid = 0; bus.s_d_data = 0; bus.s_a_ready = 0;
        tick(2);
        rst = 1'b0;
        bus.if_request = 1; bus.if_a_valid = 1; bus.if_a_address = 64'h8000_0100;
        tick(1);
        check("t6_fresh_grant_if", bus.grant_if, 1'b1);
        bus.if_request = 0; bus.if_a_valid = 0;
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single physical memory port between the instruction-fetch requester (if_*) and the memory-access requester (ma_*, after the MMU).
- Exactly one transaction is outstanding at a time.
- The grant is locked from A-channel grant until the D-channel beat completes.
- Fixed priority goes to ma, because ma stalls the pipeline. A starvation counter guarantees fetch progress.

Parameters:
- AW, 64, address width
- DW, 64, data width (mask width is DW/8)
- STARVE_MAX, 4, consecutive ma grants allowed while if is waiting before if is forced to win

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  pipeline flush; abandons a granted, not-yet-accepted fetch
- if_request / ma_request  in  1  requester wants the bus
- if_a_valid / ma_a_valid  in  1  A-channel valid
- if_a_ready / ma_a_ready  out  1  A-channel accepted
- if_a_opcode / ma_a_opcode  in  3  TileLink opcode
- if_a_address / ma_a_address  in  AW  address
- if_a_data / ma_a_data  in  DW  write data
- if_a_mask / ma_a_mask  in  DW/8  byte mask
- if_d_valid / ma_d_valid  out  1  response valid
- if_d_ready / ma_d_ready  in  1  response accepted
- if_d_data / ma_d_data  out  DW  response data
- if_d_denied / ma_d_denied  out  1  response error
- s_a_valid  out  1  slave A valid
- s_a_ready  in  1  slave A ready
- s_a_opcode / s_a_address / s_a_data / s_a_mask  out  3/AW/DW/DW/8  muxed A payload
- s_d_valid  in  1  slave D valid
- s_d_ready  out  1  slave D ready
- s_d_data  in  DW  slave D data
- s_d_denied  in  1  slave D error
- grant_if / grant_ma  out  1  registered one-hot owner indication
- busy  out  1  state != IDLE

Behaviour:

Reset (rst high, asynchronous):
- state=IDLE, owner none, starve_cnt=0.
- All valid/ready outputs 0, grant_* 0, busy 0, and every payload output 0.

Requester eligibility:
- A requester is eligible when x_request & x_a_valid.

States:

IDLE:
- All *_ready and *_valid outputs are 0.
- Only ma eligible -> grant ma.
- Only if eligible -> grant if.
- Both eligible -> grant ma unless starve_cnt==STARVE_MAX, in which case grant if.
- On grant: latch owner, set the grant_* register, go to ADDR (next cycle).
- clear in IDLE blocks granting if in that cycle.

ADDR:
- s_a_* = owner's A payload (combinational mux).
- s_a_valid = owner a_valid.
- owner a_ready = s_a_ready.
- Non-owner a_ready stays 0.
- Requesters hold the A payload stable until a_ready, per TileLink rules.
- A handshake (s_a_valid & s_a_ready) -> RESP.
- Owner drops x_request before the handshake -> IDLE, owner cleared.
- clear while owner==if and no handshake this cycle -> IDLE; s_a_valid is forced 0 that cycle.
- clear with owner==ma is ignored.

RESP:
- owner d_valid/d_data/d_denied = s_d_*.
- s_d_ready = owner d_ready.
- Non-owner d_valid stays 0.
- D handshake -> IDLE; this is single-beat, and multi-beat is out of scope.
- clear is ignored in RESP; the response is always delivered to the owner.

Slave D outside RESP:
- s_d_ready=0; the response is held off until RESP.

starve_cnt:
- +1 (saturating at STARVE_MAX) on each ma grant made while if is eligible.
- Reset to 0 on each if grant.
- Unchanged otherwise.

Timing:
- Minimum turnaround is 3 cycles: eligible@t, grant@t+1 with A fire if s_a_ready, D fire @t+2 if s_d_valid, IDLE @t+3.
- There is one idle bubble between back-to-back transactions.

Other rules:
- grant_* stays asserted through ADDR and RESP and clears on entry to IDLE.
- The payload mux selects owner; when there is no owner it outputs 0.
- Reset mid-transaction drops everything immediately. The slave is reset on the same rst.

Test Plan:
1. if-only: addr 0x8000_0000, get, s_a_ready=1, s_d_valid @+1 with data 0x0000_0013 -> grant_if @+1, if_a_ready @+1, if_d_data=0x13 @+2, busy low @+3.
2. Both request continuously with s_a_ready=s_d_valid=1 -> grants ma,ma,ma,ma then if (5th), then ma resumes; starve_cnt returns to 0 after the if grant.
3. Slave backpressure: s_a_ready=0 for 5 cycles in ADDR with owner ma, addr 0x1000 -> payload stable, ma_a_ready=0, if_a_ready=0, no D forwarded; fires on cycle 6.
4. clear in ADDR with owner if and s_a_ready=0 -> IDLE next cycle, s_a_valid never high while clear is high, if_a_ready never 1. The same clear with owner ma -> transaction completes normally.
5. Early s_d_valid=1 during IDLE -> s_d_ready=0, no d_valid on either master. D response in RESP with ma_d_ready=0 for 3 cycles -> s_d_ready=0 and data held until ma_d_ready rises; s_d_denied=1 propagates to ma_d_denied.
6. rst pulsed while in RESP -> all outputs 0 asynchronously, state IDLE; a fresh if request after rst is granted in the first eligible cycle.
